id_stage: RTL

Instruction-decode stage of the MIPS32 five-stage pipeline, sitting between the IF/ID register and the ID_EX pipeline register, which it drives directly. It holds the 32×32 general-purpose register file, decodes the main control bits, sign-extends the immediate, and forwards same-cycle write-back data into its read ports. It also detects load-use hazards and requests one stall cycle from the fetch stage plus one bubble into ID_EX.

---
 rtl/id_stage_if.sv | 54 +++++
 rtl/id_stage.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/id_stage_if.sv
// ---------------------------------------------------------------------------
// id_stage_if
// Bundle of every non-clock signal of the MIPS32 instruction-decode stage.
//   master : the pipeline around the stage (IF/ID, MEM/WB, ID_EX, fetch)
//            drives the inputs and receives the decode results.
//   slave  : the id_stage itself.
// Inputs : instr_IN, proxDir_IN, wb_regwrite, wb_writereg, wb_writedata,
//          ex_memread, ex_rt
// Outputs: proxDir_OUT, DR1_OUT, DR2_OUT, sign_extend_OUT, rt_OUT, rd_OUT,
//          regsdt, branch, memread, memtoreg, memwrite, alusrc, regwrite,
//          aluop, stall, flush_idex
// ---------------------------------------------------------------------------
interface id_stage_if;
  logic [31:0] instr_IN;
  logic [31:0] proxDir_IN;
  logic        wb_regwrite;
  logic [4:0]  wb_writereg;
  logic [31:0] wb_writedata;
  logic        ex_memread;
  logic [4:0]  ex_rt;

  logic [31:0] proxDir_OUT;
  logic [31:0] DR1_OUT;
  logic [31:0] DR2_OUT;
  logic [31:0] sign_extend_OUT;
  logic [4:0]  rt_OUT;
  logic [4:0]  rd_OUT;
  logic        regsdt;
  logic        branch;
  logic        memread;
  logic        memtoreg;
  logic        memwrite;
  logic        alusrc;
  logic        regwrite;
  logic [1:0]  aluop;
  logic        stall;
  logic        flush_idex;

  modport master (
    output instr_IN, proxDir_IN, wb_regwrite, wb_writereg, wb_writedata,
           ex_memread, ex_rt,
    input  proxDir_OUT, DR1_OUT, DR2_OUT, sign_extend_OUT, rt_OUT, rd_OUT,
           regsdt, branch, memread, memtoreg, memwrite, alusrc, regwrite,
           aluop, stall, flush_idex
  );

  modport slave (
    input  instr_IN, proxDir_IN, wb_regwrite, wb_writereg, wb_writedata,
           ex_memread, ex_rt,
    output proxDir_OUT, DR1_OUT, DR2_OUT, sign_extend_OUT, rt_OUT, rd_OUT,
           regsdt, branch, memread, memtoreg, memwrite, alusrc, regwrite,
           aluop, stall, flush_idex
  );
endinterface

// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage
// MIPS32 instruction-decode stage. Holds the 32x32 register file, decodes the
// main control bits, sign-extends the immediate, bypasses same-cycle
// write-back data into the read ports and detects load-use hazards.
// All outputs are combinational: ID_EX captures them on the same edge.
// Ports:
//   clock : pipeline clock, register file writes on the rising edge
//   reset : asynchronous active-high, clears the register file and forces
//           control / stall / flush outputs low
//   bus   : id_stage_if.slave, all data, control and hazard signals
// ---------------------------------------------------------------------------
module id_stage (
  input logic        clock,
  input logic        reset,
  id_stage_if.slave  bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // Control vector order: {regsdt, branch, memread, memtoreg, memwrite,
  //                        alusrc, regwrite, aluop[1:0]}
  localparam logic [8:0] CTRL_NOP = 9'b0_0_0_0_0_0_0_00;

  logic [31:0] regs_r [32];

  logic [5:0]  opcode_s;
  logic [4:0]  rs_s;
  logic [4:0]  rt_s;
  logic        wb_valid_s;
  logic        bypass_rs_s;
  logic        bypass_rt_s;
  logic [31:0] dr1_s;
  logic [31:0] dr2_s;
  logic [8:0]  dec_ctrl_s;
  logic        uses_rt_s;
  logic        hazard_s;
  logic [8:0]  ctrl_s;
  logic        stall_s;

  assign opcode_s   = bus.instr_IN[31:26];
  assign rs_s       = bus.instr_IN[25:21];
  assign rt_s       = bus.instr_IN[20:16];
  // Writes to $0 are discarded, so they never bypass either.
  assign wb_valid_s = bus.wb_regwrite && (bus.wb_writereg != 5'd0);

  // Register file storage: async clear, write-back commits even during a stall.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_r[i] <= 32'd0;
      end
    end else if (wb_valid_s) begin
      regs_r[bus.wb_writereg] <= bus.wb_writedata;
    end
  end

  // Read ports with same-cycle write-back bypass. Entry 0 is never written
  // and is cleared by reset, so it always reads zero from storage.
  always_comb begin
    bypass_rs_s = wb_valid_s && (bus.wb_writereg == rs_s);
    bypass_rt_s = wb_valid_s && (bus.wb_writereg == rt_s);
    if (bypass_rs_s) begin
      dr1_s = bus.wb_writedata;
    end else begin
      dr1_s = regs_r[rs_s];
    end
    if (bypass_rt_s) begin
      dr2_s = bus.wb_writedata;
    end else begin
      dr2_s = regs_r[rt_s];
    end
  end

  // Main decoder; unknown opcodes execute as NOP.
  always_comb begin
    dec_ctrl_s = CTRL_NOP;
    uses_rt_s  = 1'b0;
    case (opcode_s)
      OP_RTYPE: begin
        dec_ctrl_s = 9'b1_0_0_0_0_0_1_10;
        uses_rt_s  = 1'b1;
      end
      OP_LW: begin
        dec_ctrl_s = 9'b0_0_1_1_0_1_1_00;
        uses_rt_s  = 1'b0;
      end
      OP_SW: begin
        dec_ctrl_s = 9'b0_0_0_0_1_1_0_00;
        uses_rt_s  = 1'b1;
      end
      OP_BEQ: begin
        dec_ctrl_s = 9'b0_1_0_0_0_0_0_01;
        uses_rt_s  = 1'b1;
      end
      OP_ADDI: begin
        dec_ctrl_s = 9'b0_0_0_0_0_1_1_00;
        uses_rt_s  = 1'b0;
      end
      default: begin
        dec_ctrl_s = CTRL_NOP;
        uses_rt_s  = 1'b0;
      end
    endcase
  end

  // Load-use detection. rt only counts as a source for R-type, sw and beq;
  // for lw/addi it is the destination. Reset masks the whole stage.
  always_comb begin
    hazard_s = bus.ex_memread && (bus.ex_rt != 5'd0) &&
               ((bus.ex_rt == rs_s) || ((bus.ex_rt == rt_s) && uses_rt_s));
    if (reset || hazard_s) begin
      ctrl_s = CTRL_NOP;
    end else begin
      ctrl_s = dec_ctrl_s;
    end
    if (reset) begin
      stall_s = 1'b0;
    end else begin
      stall_s = hazard_s;
    end
  end

  assign bus.proxDir_OUT     = bus.proxDir_IN;
  assign bus.DR1_OUT         = dr1_s;
  assign bus.DR2_OUT         = dr2_s;
  assign bus.sign_extend_OUT = {{16{bus.instr_IN[15]}}, bus.instr_IN[15:0]};
  assign bus.rt_OUT          = bus.instr_IN[20:16];
  assign bus.rd_OUT          = bus.instr_IN[15:11];
  assign bus.regsdt          = ctrl_s[8];
  assign bus.branch          = ctrl_s[7];
  assign bus.memread         = ctrl_s[6];
  assign bus.memtoreg        = ctrl_s[5];
  assign bus.memwrite        = ctrl_s[4];
  assign bus.alusrc          = ctrl_s[3];
  assign bus.regwrite        = ctrl_s[2];
  assign bus.aluop           = ctrl_s[1:0];
  assign bus.stall           = stall_s;
  assign bus.flush_idex      = stall_s;

endmodule
